// File: rtl/vedic_mult_pipe.sv
// ---------------------------------------------------------------------------
// vedic_mult_pipe
//
// Pipelined unsigned Urdhva-Tiryagbhyam ("vertically and crosswise")
// multiplier for any operand width. Each operand is split into a high and a
// low half. The vertical products (low*low, high*high) and the crosswise sum
// (high*low + low*high) are formed in one stage and recombined in the next.
// It serves as the mantissa-product engine of the double-precision FP
// multiplier.
//
// Pipeline: S1 operand capture -> S2 partial products -> S3 recombination.
// All three stages advance together under a single enable. That enable is
// open whenever the output slot is empty or is being drained this cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand pair present on a / b / in_tag
//   in_ready   pipe can accept an operand pair this cycle (combinational)
//   a, b       WIDTH-bit unsigned operands
//   in_tag     TAG_W-bit opaque tag, returned with the result
//   out_valid  result present on p / out_tag
//   out_ready  downstream accepts the result
//   p          2*WIDTH-bit exact unsigned product
//   out_tag    tag of the operation on p
// ---------------------------------------------------------------------------
module vedic_mult_pipe #(
  parameter int WIDTH = 53,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic [TAG_W-1:0]     out_tag
);

  // L is the low-half width and H the high-half width. For odd WIDTH the
  // high half gets the extra bit.
  localparam int L  = WIDTH / 2;
  localparam int H  = WIDTH - L;
  localparam int PW = 2 * WIDTH;
  // The crosswise sum of two H*L products needs one extra bit for its carry.
  localparam int XW = WIDTH + 1;

  logic en;

  // Stage 1 registers
  logic               v1;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic [TAG_W-1:0]   tag1;

  // Stage 2 combinational partial products
  logic [L-1:0]       a_lo;
  logic [H-1:0]       a_hi;
  logic [L-1:0]       b_lo;
  logic [H-1:0]       b_hi;
  logic [2*L-1:0]     ll_c;
  logic [2*H-1:0]     hh_c;
  logic [XW-1:0]      x_c;

  // Stage 2 registers
  logic               v2;
  logic [2*L-1:0]     pp_ll;
  logic [2*H-1:0]     pp_hh;
  logic [XW-1:0]      pp_x;
  logic [TAG_W-1:0]   tag2;

  // Stage 3 recombination, one bit wider so an overflow can be observed
  logic [PW:0]        sum_c;

  // Stage 3 registers
  logic               v3;

  // The whole pipe moves as one. A full output slot that is not being
  // drained freezes every stage. This is what keeps p / out_tag stable
  // under backpressure and closes in_ready at the same time.
  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;

  // Stage 1: capture the operands. The valid bit records whether this slot
  // really holds an accepted pair. The data may be loaded from idle inputs,
  // which is harmless because the valid bit travels with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      tag1 <= '0;
    end else if (en) begin
      v1   <= in_valid;
      a1   <= a;
      b1   <= b;
      tag1 <= in_tag;
    end
  end

  // Split the captured operands into halves: x = x_hi * 2^L + x_lo.
  assign a_lo = a1[L-1:0];
  assign a_hi = a1[WIDTH-1:L];
  assign b_lo = b1[L-1:0];
  assign b_hi = b1[WIDTH-1:L];

  // Vertical and crosswise products. Each factor is zero-extended to the
  // result width first, so the multiply is evaluated exactly and no carry
  // is dropped by SystemVerilog's context-width rules.
  always_comb begin
    ll_c = {{L{1'b0}}, a_lo} * {{L{1'b0}}, b_lo};
    hh_c = {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_hi};
    x_c  = ({{(XW-H){1'b0}}, a_hi} * {{(XW-L){1'b0}}, b_lo})
         + ({{(XW-L){1'b0}}, a_lo} * {{(XW-H){1'b0}}, b_hi});
  end

  // Stage 2: register the three partial products together with their tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      pp_ll <= '0;
      pp_hh <= '0;
      pp_x  <= '0;
      tag2  <= '0;
    end else if (en) begin
      v2    <= v1;
      pp_ll <= ll_c;
      pp_hh <= hh_c;
      pp_x  <= x_c;
      tag2  <= tag1;
    end
  end

  // Recombine: p = hh * 2^(2L) + x * 2^L + ll. The top bit of sum_c is
  // always zero for a legal product. It is kept only so the overflow check
  // below has something to look at.
  always_comb begin
    sum_c = ({{(PW+1-2*H){1'b0}}, pp_hh} << (2*L))
          + ({{(PW+1-XW){1'b0}}, pp_x} << L)
          + {{(PW+1-2*L){1'b0}}, pp_ll};
  end

  // Stage 3: the output register. v3 is out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3      <= 1'b0;
      p       <= '0;
      out_tag <= '0;
    end else if (en) begin
      v3      <= v2;
      p       <= sum_c[PW-1:0];
      out_tag <= tag2;
    end
  end

  // A carry out of the product's top bit means the recombination is broken.
  a_no_carry_out: assert property (
    @(posedge clk) disable iff (rst) (v2 && en) |-> !sum_c[PW]
  );

  // A stalled result must not move, vanish or let a new pair in.
  a_stall_stable: assert property (
    @(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(p) && $stable(out_tag))
  );

  a_stall_closes_input: assert property (
    @(posedge clk) disable iff (rst) (out_valid && !out_ready) |-> !in_ready
  );

endmodule
